// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips32_pkg
// Purpose : Shared opcodes, instruction field positions, controller state
//           encoding and register constants for the pipe_MIPS32 interlock.
// Revision: 1.0 - initial release
// ============================================================================
package mips32_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] c_op_add   = 6'h00;
  localparam logic [5:0] c_op_sub   = 6'h01;
  localparam logic [5:0] c_op_and   = 6'h02;
  localparam logic [5:0] c_op_or    = 6'h03;
  localparam logic [5:0] c_op_slt   = 6'h04;
  localparam logic [5:0] c_op_mul   = 6'h05;
  localparam logic [5:0] c_op_lw    = 6'h08;
  localparam logic [5:0] c_op_sw    = 6'h09;
  localparam logic [5:0] c_op_addi  = 6'h0A;
  localparam logic [5:0] c_op_subi  = 6'h0B;
  localparam logic [5:0] c_op_slti  = 6'h0C;
  localparam logic [5:0] c_op_bneqz = 6'h0D;
  localparam logic [5:0] c_op_beqz  = 6'h0E;
  localparam logic [5:0] c_op_hlt   = 6'h3F;

  // Instruction field bit positions
  localparam int c_opc_msb = 31;
  localparam int c_opc_lsb = 26;
  localparam int c_rs_msb  = 25;
  localparam int c_rs_lsb  = 21;
  localparam int c_rt_msb  = 20;
  localparam int c_rt_lsb  = 16;
  localparam int c_rd_msb  = 15;
  localparam int c_rd_lsb  = 11;

  // Hard-wired zero register: never a real producer or consumer
  localparam logic [4:0] c_r0 = 5'd0;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t c_st_idle   = 2'd0;
  localparam state_t c_st_run    = 2'd1;
  localparam state_t c_st_drain  = 2'd2;
  localparam state_t c_st_halted = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mips32_instr_decode.sv
`default_nettype none
// ============================================================================
// Module  : mips32_instr_decode
// Purpose : Combinational decode of the IF/ID instruction into its
//           destination register and the source registers it reads.
// Revision: 1.0 - initial release
// ============================================================================
module mips32_instr_decode
  import mips32_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_has_dst,
  output logic [4:0]  o_dst,
  output logic        o_use_rs,
  output logic        o_use_rt,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic        o_is_hlt
);

  logic [5:0] w_op;
  logic [4:0] w_rd;
  logic       w_unused_imm;

  assign w_op         = i_instr[c_opc_msb:c_opc_lsb];
  assign o_rs         = i_instr[c_rs_msb:c_rs_lsb];
  assign o_rt         = i_instr[c_rt_msb:c_rt_lsb];
  assign w_rd         = i_instr[c_rd_msb:c_rd_lsb];
  // Low immediate/funct bits never name a register
  assign w_unused_imm = ^i_instr[c_rd_lsb-1:0];

  // Classify opcode; R0 fields are dropped so they can never create a hazard
  always_comb begin
    o_has_dst = 1'b0;
    o_dst     = c_r0;
    o_use_rs  = 1'b0;
    o_use_rt  = 1'b0;
    o_is_hlt  = 1'b0;
    case (w_op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul: begin
        o_has_dst = (w_rd != c_r0);
        o_dst     = w_rd;
        o_use_rs  = (o_rs != c_r0);
        o_use_rt  = (o_rt != c_r0);
      end
      c_op_addi, c_op_subi, c_op_slti, c_op_lw: begin
        o_has_dst = (o_rt != c_r0);
        o_dst     = o_rt;
        o_use_rs  = (o_rs != c_r0);
      end
      c_op_sw: begin
        o_use_rs  = (o_rs != c_r0);
        o_use_rt  = (o_rt != c_r0);
      end
      c_op_bneqz, c_op_beqz: begin
        o_use_rs  = (o_rs != c_r0);
      end
      c_op_hlt: begin
        o_is_hlt  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips32_hazard_ctrl
// Purpose : RAW interlock, branch squash and start/HLT-drain sequencing for
//           the pipe_MIPS32 pipeline. Tracks destinations in EX and MEM.
// Revision: 1.0 - initial release
// ============================================================================
module mips32_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             br_taken,
  output logic             fetch_en,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int c_drw = $clog2(DRAIN_CYCLES + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ex_v;
  logic [4:0]       r_ex_dst;
  logic             r_mem_v;
  logic [4:0]       r_mem_dst;
  logic [c_drw-1:0] r_drain;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_has_dst;
  logic [4:0]       w_dst;
  logic             w_use_rs;
  logic             w_use_rt;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_is_hlt;
  logic             w_active;
  logic             w_idle_like;
  logic             w_start_acc;
  logic             w_hit;
  logic             w_stall;
  logic             w_flush;
  logic             w_hlt_acc;

  mips32_instr_decode u_decode (
    .i_instr   (id_instr),
    .o_has_dst (w_has_dst),
    .o_dst     (w_dst),
    .o_use_rs  (w_use_rs),
    .o_use_rt  (w_use_rt),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_is_hlt  (w_is_hlt)
  );

  assign w_active    = (r_state == c_st_run) || (r_state == c_st_drain);
  assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_halted);
  assign w_start_acc = start && w_idle_like;

  // WB is not checked: the register file writes before it reads
  assign w_hit = (w_use_rs && ((r_ex_v  && (r_ex_dst  == w_rs)) ||
                               (r_mem_v && (r_mem_dst == w_rs)))) ||
                 (w_use_rt && ((r_ex_v  && (r_ex_dst  == w_rt)) ||
                               (r_mem_v && (r_mem_dst == w_rt))));

  // A taken branch squashes the consumer, so it overrides the interlock
  assign w_stall   = (r_state == c_st_run) && id_valid && !br_taken && w_hit;
  assign w_flush   = br_taken && w_active;
  assign w_hlt_acc = (r_state == c_st_run) && id_valid && w_is_hlt && !w_stall && !w_flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle, c_st_halted: begin
        if (start) w_next_state = c_st_run;
      end
      c_st_run: begin
        if (w_hlt_acc) w_next_state = c_st_drain;
      end
      c_st_drain: begin
        // A taken branch means the HLT was fetched down the wrong path
        if (br_taken)                    w_next_state = c_st_run;
        else if (r_drain <= c_drw'(1))   w_next_state = c_st_halted;
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Outputs decoded from state and the hazard compare
  always_comb begin
    fetch_en  = (r_state == c_st_run);
    halted    = (r_state == c_st_halted);
    stall     = w_stall;
    flush     = w_flush;
    stall_cnt = r_stall_cnt;
  end

  // Drain down-counter: one count per stage still retiring behind the HLT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_drain <= '0;
    else if (w_hlt_acc)                 r_drain <= c_drw'(DRAIN_CYCLES);
    else if ((r_state == c_st_drain) && (r_drain != '0))
                                        r_drain <= r_drain - c_drw'(1);
  end

  // Shadow destination slots advance with the pipeline while it is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v    <= 1'b0;
      r_ex_dst  <= c_r0;
      r_mem_v   <= 1'b0;
      r_mem_dst <= c_r0;
    end else if (w_start_acc) begin
      r_ex_v    <= 1'b0;
      r_ex_dst  <= c_r0;
      r_mem_v   <= 1'b0;
      r_mem_dst <= c_r0;
    end else if (w_active) begin
      r_mem_v   <= r_ex_v;
      r_mem_dst <= r_ex_dst;
      r_ex_v    <= w_has_dst && id_valid && !w_stall && !w_flush;
      r_ex_dst  <= w_dst;
    end
  end

  // Saturating count of interlock cycles since the last start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_stall_cnt <= '0;
    else if (w_start_acc)                 r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt))  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips32_hazard_ctrl
// Purpose : Directed self-checking bench for mips32_hazard_ctrl, ending with
//           a factorial program run on a small 5-stage pipeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips32_hazard_ctrl;

  localparam logic [31:0] c_addi_r10 = 32'h280a00c8; // ADDI R10,R0,200
  localparam logic [31:0] c_lw_r3    = 32'h21430000; // LW   R3,0(R10)
  localparam logic [31:0] c_or_fill  = 32'h0e94a000; // OR   R20,R20,R20
  localparam logic [31:0] c_addi_r0  = 32'h28000005; // ADDI R0,R0,5
  localparam logic [31:0] c_add_r1   = 32'h00000800; // ADD  R1,R0,R0
  localparam logic [31:0] c_mul_r2   = 32'h14431000; // MUL  R2,R2,R3
  localparam logic [31:0] c_sw_r2    = 32'h2542fffe; // SW   R2,-2(R10)
  localparam logic [31:0] c_add_r4   = 32'h00602000; // ADD  R4,R3,R0
  localparam logic [31:0] c_hlt      = 32'hfc000000; // HLT

  logic        clk, rst_n, start, id_valid, br_taken;
  logic [31:0] id_instr;
  logic        fetch_en, stall, flush, halted;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int ns;

  mips32_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .br_taken  (br_taken),
    .fetch_en  (fetch_en),
    .stall     (stall),
    .flush     (flush),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one instruction in ID until it is accepted; report stall cycles
  task automatic issue(input logic [31:0] ins, output int nst);
    nst = 0;
    id_valid = 1'b1;
    id_instr = ins;
    #1;
    while (stall && nst < 8) begin
      nst++;
      @(negedge clk); #1;
    end
    @(posedge clk);
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- 5-stage pipeline model for the integrated run ----------
  logic [31:0] imem [0:15];
  logic [31:0] dmem [0:255];
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic        ifid_v, idex_v, exmem_v, memwb_v;
  logic [31:0] ifid_ir, ifid_npc;
  logic [31:0] idex_ir, idex_a, idex_b, idex_imm, idex_npc;
  logic [31:0] exmem_ir, exmem_alu, exmem_b;
  logic [31:0] memwb_ir, memwb_alu, memwb_lmd;
  logic        halt_seen;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] alu_f(input logic [31:0] ir, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
    case (ir[31:26])
      6'h00:        return a + b;
      6'h01:        return a - b;
      6'h02:        return a & b;
      6'h03:        return a | b;
      6'h04:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h05:        return a * b;
      6'h0A:        return a + imm;
      6'h0B:        return a - imm;
      6'h0C:        return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      6'h08, 6'h09: return a + imm;
      default:      return 32'd0;
    endcase
  endfunction

  task automatic pipe_cycle();
    logic        br, iv, s, f, fe;
    logic [31:0] tgt;
    logic [5:0]  op;
    br  = idex_v && (((idex_ir[31:26] == 6'h0D) && (idex_a != 32'd0)) ||
                     ((idex_ir[31:26] == 6'h0E) && (idex_a == 32'd0)));
    tgt = idex_npc + idex_imm;
    fe  = fetch_en;
    iv  = ifid_v && fe;
    br_taken = br;
    id_valid = iv;
    id_instr = ifid_ir;
    #1;
    s = stall;
    f = flush;
    if (halted) halt_seen = 1'b1;
    @(posedge clk);
    // WB (writes land before the ID read below)
    if (memwb_v) begin
      op = memwb_ir[31:26];
      if (op <= 6'h05)                      regs[memwb_ir[15:11]] = memwb_alu;
      else if (op >= 6'h0A && op <= 6'h0C) regs[memwb_ir[20:16]] = memwb_alu;
      else if (op == 6'h08)                 regs[memwb_ir[20:16]] = memwb_lmd;
      regs[0] = 32'd0;
    end
    // MEM
    memwb_v   = exmem_v;
    memwb_ir  = exmem_ir;
    memwb_alu = exmem_alu;
    if (exmem_v && exmem_ir[31:26] == 6'h08) memwb_lmd = dmem[exmem_alu[7:0]];
    if (exmem_v && exmem_ir[31:26] == 6'h09) dmem[exmem_alu[7:0]] = exmem_b;
    // EX
    exmem_v   = idex_v;
    exmem_ir  = idex_ir;
    exmem_alu = alu_f(idex_ir, idex_a, idex_b, idex_imm);
    exmem_b   = idex_b;
    // ID
    if (f || s || !iv) begin
      idex_v = 1'b0;
    end else begin
      idex_v   = 1'b1;
      idex_ir  = ifid_ir;
      idex_a   = regs[ifid_ir[25:21]];
      idex_b   = regs[ifid_ir[20:16]];
      idex_imm = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
      idex_npc = ifid_npc;
    end
    // IF
    if (f) begin
      ifid_v = 1'b0;
      pc     = tgt;
    end else if (s) begin
      // hold PC and IF/ID
    end else if (fe) begin
      ifid_v   = 1'b1;
      ifid_ir  = imem[pc[3:0]];
      ifid_npc = pc + 32'd1;
      pc       = pc + 32'd1;
    end else begin
      ifid_v = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    id_valid = 1'b0; id_instr = 32'd0; br_taken = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk1 ("rst_fetch_en", fetch_en, 1'b0);
    chk1 ("rst_stall",    stall,    1'b0);
    chk1 ("rst_flush",    flush,    1'b0);
    chk1 ("rst_halted",   halted,   1'b0);
    chk32("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    #1 chk1("start_fetch_en", fetch_en, 1'b1);

    // Back-to-back producer/consumer: 2-cycle interlock
    issue(c_addi_r10, ns); chk32("t1_addi_ns", ns, 0);
    issue(c_lw_r3, ns);    chk32("t1_lw_ns", ns, 2);
    #1 chk32("t1_stall_cnt", 32'(stall_cnt), 32'd2);

    // One filler: 1 cycle; two (self-dependent) fillers: LW does not stall
    idle(2);
    issue(c_addi_r10, ns);
    issue(c_or_fill, ns);  chk32("t2_or_ns", ns, 0);
    issue(c_lw_r3, ns);    chk32("t2_lw_1fill_ns", ns, 1);
    idle(2);
    issue(c_addi_r10, ns);
    issue(c_or_fill, ns);
    issue(c_or_fill, ns);  chk32("t2_or2_ns", ns, 2);
    issue(c_lw_r3, ns);    chk32("t2_lw_2fill_ns", ns, 0);
    #1 chk32("t2_stall_cnt", 32'(stall_cnt), 32'd5);

    // R0 never hazards; SW interlocks on rt
    idle(2);
    issue(c_addi_r0, ns);  chk32("t3_addi_r0_ns", ns, 0);
    issue(c_add_r1, ns);   chk32("t3_add_r0src_ns", ns, 0);
    issue(c_mul_r2, ns);   chk32("t3_mul_ns", ns, 0);
    issue(c_sw_r2, ns);    chk32("t3_sw_rt_ns", ns, 2);
    #1 chk32("t3_stall_cnt", 32'(stall_cnt), 32'd7);

    // Hazard and taken branch together: flush wins, consumer becomes bubble
    idle(2);
    issue(c_addi_r10, ns);
    id_instr = c_lw_r3; id_valid = 1'b1; br_taken = 1'b1;
    #1;
    chk1("t4_flush", flush, 1'b1);
    chk1("t4_stall", stall, 1'b0);
    @(posedge clk); @(negedge clk);
    br_taken = 1'b0;
    issue(c_add_r4, ns);   chk32("t4_ex_bubble_ns", ns, 0);
    #1 chk32("t4_stall_cnt", 32'(stall_cnt), 32'd7);

    // start while running is ignored
    do_start();
    #1;
    chk32("run_start_ign_cnt", 32'(stall_cnt), 32'd7);
    chk1 ("run_start_ign_fe",  fetch_en, 1'b1);

    // HLT drain: fetch stops next cycle, halted after 3 cycles
    idle(2);
    issue(c_hlt, ns);      chk32("t5_hlt_ns", ns, 0);
    #1;
    chk1("t5_drain_fe",     fetch_en, 1'b0);
    chk1("t5_drain_halted", halted,   1'b0);
    @(negedge clk); @(negedge clk); #1;
    chk1("t5_halted_e2",    halted,   1'b0);
    @(negedge clk); #1;
    chk1("t5_halted_e3",    halted,   1'b1);
    chk1("t5_halted_fe",    fetch_en, 1'b0);
    id_instr = c_lw_r3; id_valid = 1'b1; br_taken = 1'b1;
    #1;
    chk1("t5_halt_flush", flush, 1'b0);
    chk1("t5_halt_stall", stall, 1'b0);
    br_taken = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    do_start();
    #1;
    chk32("t5_restart_cnt", 32'(stall_cnt), 32'd0);
    chk1 ("t5_restart_fe",  fetch_en, 1'b1);
    chk1 ("t5_restart_hlt", halted,   1'b0);

    // Taken branch during DRAIN returns to RUN; no interlock in DRAIN
    issue(c_addi_r10, ns);
    issue(c_hlt, ns);
    id_instr = c_lw_r3; id_valid = 1'b1;
    #1 chk1("t5_drain_nostall", stall, 1'b0);
    br_taken = 1'b1;
    #1 chk1("t5_drain_flush", flush, 1'b1);
    @(posedge clk); @(negedge clk);
    br_taken = 1'b0; id_valid = 1'b0;
    #1;
    chk1("t5_br_run_fe",  fetch_en, 1'b1);
    chk1("t5_br_run_hlt", halted,   1'b0);

    // Asynchronous reset in the middle of a stall
    idle(2);
    issue(c_addi_r10, ns);
    id_instr = c_lw_r3; id_valid = 1'b1;
    #1 chk1("t6_pre_stall", stall, 1'b1);
    @(posedge clk); @(negedge clk); #1;
    chk32("t6_pre_cnt", 32'(stall_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk1 ("t6_rst_stall", stall,    1'b0);
    chk1 ("t6_rst_fe",    fetch_en, 1'b0);
    chk1 ("t6_rst_flush", flush,    1'b0);
    chk1 ("t6_rst_halt",  halted,   1'b0);
    chk32("t6_rst_cnt",   32'(stall_cnt), 32'd0);
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Factorial of 7 with no filler instructions
    for (int i = 0; i < 16; i++)  imem[i] = c_hlt;
    for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 32; i++)  regs[i] = 32'd0;
    imem[0] = enc_i(6'h0A, 5'd0, 5'd10, 16'd200);   // ADDI R10,R0,200
    imem[1] = enc_i(6'h0A, 5'd0, 5'd2, 16'd1);      // ADDI R2,R0,1
    imem[2] = enc_i(6'h08, 5'd10, 5'd3, 16'd0);     // LW   R3,0(R10)
    imem[3] = enc_r(6'h05, 5'd2, 5'd3, 5'd2);       // MUL  R2,R2,R3
    imem[4] = enc_i(6'h0B, 5'd3, 5'd3, 16'd1);      // SUBI R3,R3,1
    imem[5] = enc_i(6'h0D, 5'd3, 5'd0, 16'hfffd);   // BNEQZ R3,-3
    imem[6] = enc_i(6'h09, 5'd10, 5'd2, 16'hfffe);  // SW   R2,-2(R10)
    imem[7] = c_hlt;
    dmem[200] = 32'd7;
    pc = 32'd0;
    ifid_v = 1'b0; idex_v = 1'b0; exmem_v = 1'b0; memwb_v = 1'b0;
    ifid_ir = 32'd0; ifid_npc = 32'd0;
    idex_ir = 32'd0; idex_a = 32'd0; idex_b = 32'd0; idex_imm = 32'd0; idex_npc = 32'd0;
    exmem_ir = 32'd0; exmem_alu = 32'd0; exmem_b = 32'd0;
    memwb_ir = 32'd0; memwb_alu = 32'd0; memwb_lmd = 32'd0;
    halt_seen = 1'b0;
    start = 1'b1;
    pipe_cycle();
    start = 1'b0;
    for (int c = 0; c < 600 && !halt_seen; c++) pipe_cycle();
    chk1 ("fact_halted",   halt_seen, 1'b1);
    chk32("fact_mem198",   dmem[198], 32'd5040);
    chk32("fact_r2",       regs[2],   32'd5040);
    chk32("fact_r3",       regs[3],   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
